// File: rtl/memory_read_responder_pkg.sv
// Shared memory-system constants used by the read responder and the cache fill FSM.
package memory_read_responder_pkg;

    localparam int unsigned MEM_LATENCY       = 4;
    localparam int unsigned MEM_WORD_WIDTH    = 16;
    localparam int unsigned MEM_ADDR_WIDTH    = 16;
    localparam int unsigned CACHE_BLOCK_WORDS = 8;

endpackage : memory_read_responder_pkg

// File: rtl/mem_pipe_stage.sv
// One slot of the read-response pipeline: a valid bit with synchronous clear plus its data word.
module mem_pipe_stage
    import memory_read_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MEM_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
        end
    end

    // NOTE: the data word is qualified by valid_q, so it needs no reset and stays a plain register.
    always_ff @(posedge clk) begin
        data_q <= data_i;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : mem_pipe_stage

// File: rtl/memory_read_responder.sv
// Main-memory model for the cache fill FSM: word array plus a fixed-latency read pipeline.
module memory_read_responder
    import memory_read_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = MEM_WORD_WIDTH,
    parameter int unsigned LATENCY    = MEM_LATENCY     // legal range 1..8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] memory_address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] memory_data,
    output logic                  memory_data_valid,
    output logic                  busy
);

    localparam int unsigned DEPTH = 1 << (ADDR_WIDTH - 1);

    logic [ADDR_WIDTH-2:0] word_idx;
    logic                  read_req;
    logic                  unused_addr_lsb;

    assign word_idx        = memory_address[ADDR_WIDTH-1:1];
    assign unused_addr_lsb = memory_address[0];
    assign read_req        = enable & ~wr;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: memory arrays are never reset; contents survive rst_n and start undefined.
    always_ff @(posedge clk) begin
        if (enable && wr) begin
            mem_q[word_idx] <= data_in;
        end
    end

    logic [LATENCY-1:0]    stage_valid;
    logic [DATA_WIDTH-1:0] stage_data [LATENCY];

    // Stage 0 snapshots the array at the request edge, so later writes cannot alter an issued read.
    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        if (s == 0) begin : g_head
            mem_pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .valid_i (read_req),
                .data_i  (mem_q[word_idx]),
                .valid_o (stage_valid[s]),
                .data_o  (stage_data[s])
            );
        end else begin : g_body
            mem_pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .valid_i (stage_valid[s-1]),
                .data_i  (stage_data[s-1]),
                .valid_o (stage_valid[s]),
                .data_o  (stage_data[s])
            );
        end
    end

    assign memory_data_valid = stage_valid[LATENCY-1];
    assign memory_data       = stage_valid[LATENCY-1] ? stage_data[LATENCY-1] : '0;
    assign busy              = |stage_valid;

endmodule : memory_read_responder

// File: tb/tb_memory_read_responder.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based response model.
module tb_memory_read_responder;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        wr;
    logic [15:0] memory_address;
    logic [15:0] data_in;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        busy;

    memory_read_responder #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .LATENCY    (L)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .wr                (wr),
        .memory_address    (memory_address),
        .data_in           (data_in),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
    } resp_t;

    resp_t       pending[$];
    logic [15:0] model_mem [int];
    int          pulse_edge[$];
    logic [15:0] pulse_data[$];
    int          edge_no = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_no, got, exp);
    endtask

    // One clock: apply inputs, advance the model at the edge, compare outputs just after it.
    task automatic step(input logic rst, input logic en, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
        logic        exp_v;
        logic        exp_b;
        logic [15:0] exp_d;
        int          idx;
        rst_n = rst; enable = en; wr = w; memory_address = a; data_in = d;
        @(posedge clk);
        edge_no++;
        idx = int'(a >> 1);
        if (!rst) pending.delete();
        else if (en && !w)
            pending.push_back('{due: edge_no + L - 1,
                                data: model_mem.exists(idx) ? model_mem[idx] : 16'h0});
        if (en && w) model_mem[idx] = d;
        #1;
        exp_b = pending.size() > 0;
        exp_v = exp_b && pending[0].due == edge_no;
        exp_d = exp_v ? pending[0].data : 16'h0;
        if (exp_v) void'(pending.pop_front());
        check("valid", 32'(memory_data_valid), 32'(exp_v));
        check("data",  32'(memory_data),       32'(exp_d));
        check("busy",  32'(busy),              32'(exp_b));
        if (memory_data_valid) begin
            pulse_edge.push_back(edge_no);
            pulse_data.push_back(memory_data);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
        step(1'b1, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd_word(input logic [15:0] a);
        step(1'b1, 1'b1, 1'b0, a, 16'h0);
    endtask

    task automatic clear_pulses();
        pulse_edge.delete();
        pulse_data.delete();
    endtask

    initial begin
        int r;
        int s;
        int first;

        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(2);

        // Single read latency and zero bus around the pulse.
        wr_word(16'h0010, 16'hBEEF);
        idle(1);
        clear_pulses();
        rd_word(16'h0010);
        r = edge_no;
        idle(L + 1);
        check("t1_pulses", 32'(pulse_edge.size()), 32'd1);
        if (pulse_edge.size() > 0) begin
            check("t1_edge", 32'(pulse_edge[0]), 32'(r + L - 1));
            check("t1_data", 32'(pulse_data[0]), 32'hBEEF);
        end

        // Eight back-to-back reads stream out in order on consecutive cycles.
        for (int i = 0; i < 8; i++) wr_word(16'h0100 + 16'(2 * i), 16'h1000 + 16'(i));
        clear_pulses();
        for (int i = 0; i < 8; i++) begin
            rd_word(16'h0100 + 16'(2 * i));
            if (i == 0) s = edge_no;
        end
        idle(L + 1);
        check("t2_pulses", 32'(pulse_edge.size()), 32'd8);
        for (int i = 0; i < pulse_edge.size(); i++) begin
            check("t2_edge", 32'(pulse_edge[i]), 32'(s + i + L - 1));
            check("t2_data", 32'(pulse_data[i]), 32'h1000 + 32'(i));
        end
        check("t2_busy_idle", 32'(busy), 32'd0);

        // Address bit 0 ignored.
        wr_word(16'h0010, 16'h1234);
        clear_pulses();
        rd_word(16'h0011);
        idle(L);
        check("t3_pulses", 32'(pulse_edge.size()), 32'd1);
        if (pulse_data.size() > 0) check("t3_data", 32'(pulse_data[0]), 32'h1234);

        // Snapshot at issue versus read-after-write.
        wr_word(16'h0200, 16'hAAAA);
        idle(1);
        clear_pulses();
        rd_word(16'h0200);
        wr_word(16'h0200, 16'h5555);
        rd_word(16'h0200);
        idle(L);
        check("t4_pulses", 32'(pulse_edge.size()), 32'd2);
        if (pulse_data.size() == 2) begin
            check("t4_old", 32'(pulse_data[0]), 32'hAAAA);
            check("t4_new", 32'(pulse_data[1]), 32'h5555);
            check("t4_gap", 32'(pulse_edge[1] - pulse_edge[0]), 32'd2);
        end

        // Reset drops in-flight reads but keeps the array.
        clear_pulses();
        rd_word(16'h0100);
        rd_word(16'h0102);
        rd_word(16'h0104);
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        check("t5_busy_rst", 32'(busy), 32'd0);
        idle(8);
        check("t5_pulses", 32'(pulse_edge.size()), 32'd0);
        clear_pulses();
        rd_word(16'h0200);
        idle(L);
        if (pulse_data.size() > 0) check("t5_retained", 32'(pulse_data[0]), 32'h5555);
        else check("t5_retained_pulse", 32'd0, 32'd1);

        // Alternating enable gives pulses two cycles apart.
        clear_pulses();
        for (int i = 0; i < 5; i++) begin
            rd_word(16'h0100 + 16'(2 * i));
            if (i == 0) first = edge_no;
            idle(1);
        end
        idle(L);
        check("t6_pulses", 32'(pulse_edge.size()), 32'd5);
        if (pulse_edge.size() > 0) check("t6_first", 32'(pulse_edge[0]), 32'(first + L - 1));
        for (int i = 1; i < pulse_edge.size(); i++)
            check("t6_gap", 32'(pulse_edge[i] - pulse_edge[i-1]), 32'd2);

        // Random traffic over a pre-initialised window, with occasional resets.
        for (int i = 0; i < 64; i++) wr_word(16'(2 * i), 16'($urandom));
        for (int i = 0; i < 600; i++) begin
            logic        rst_r;
            logic        en_r;
            logic        wr_r;
            logic [15:0] a_r;
            rst_r = ($urandom_range(0, 49) != 0);
            en_r  = rst_r && ($urandom_range(0, 3) != 0);
            wr_r  = ($urandom_range(0, 2) == 0);
            a_r   = 16'($urandom_range(0, 127));
            step(rst_r, en_r, wr_r, a_r, 16'($urandom));
        end
        idle(L + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_memory_read_responder

// File: doc/memory_read_responder.md
Name: memory_read_responder

Overview:
- Main-memory model that responds to the cache fill FSM on the memory side.
- Byte-addressed memory, 64KB, organised as 2-byte words.
- Accepts one read or write request per cycle, fully pipelined; no stall.
- Returns read data exactly LATENCY cycles after the request, qualified by memory_data_valid; this is the signal the fill FSM waits on.

Parameters:
- ADDR_WIDTH, 16, byte address width; word array depth is 2^(ADDR_WIDTH-1).
- DATA_WIDTH, 16, word width in bits.
- LATENCY, 4, cycles from read request to memory_data_valid; legal range 1..8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- enable  input  1  request strobe; one request per cycle when high.
- wr  input  1  1 = write, 0 = read; ignored when enable=0.
- memory_address  input  ADDR_WIDTH  byte address; bit 0 ignored (word aligned).
- data_in  input  DATA_WIDTH  write data; used only when enable&wr.
- memory_data  output  DATA_WIDTH  read data; 0 whenever memory_data_valid=0.
- memory_data_valid  output  1  high for exactly one cycle per accepted read.
- busy  output  1  high while any read is in flight (for debug and bench checks).

Behaviour:
- Reset (rst_n=0 at the edge):
  - All pipeline valid bits clear; memory_data_valid=0, memory_data=0, busy=0.
  - Array contents are not reset.
  - Reset during in-flight reads drops them silently; no valid pulse follows reset.
- Word index is memory_address[ADDR_WIDTH-1:1].
- Write (enable=1, wr=1): array[word] <= data_in at that edge. No response and no pipeline entry.
- Read (enable=1, wr=0):
  - The word is sampled at the request edge into stage 1 of a LATENCY-deep pipeline (valid + data).
  - The pipeline shifts every cycle.
  - The output is the last stage, so a read requested in cycle N (sampled at edge N) gives memory_data_valid=1 in cycle N+LATENCY.
- Back-to-back reads: one per cycle gives valid pulses on consecutive cycles, in request order. Eight reads in cycles 0..7 give valid in cycles 4..11.
- Read-after-write:
  - A write at edge N followed by a read of the same word at edge N+1 or later returns the new data.
  - Data sampled into the pipeline is not affected by later writes (snapshot at issue).
- Same-cycle conflict: wr selects exactly one operation, so no conflict exists.
- enable=0: no array change and no new pipeline entry; in-flight reads still drain.
- busy = OR of all pipeline valid bits.
- Address wrap: none needed; every ADDR_WIDTH value maps to a word.
- memory_data is forced to 0 when the output stage is invalid, so there is no X or stale data on the bus.
- No state machine is required; the control state is entirely the valid shift register. At most LATENCY reads are in flight.

Decomposition:
- Shared include mem_defs.vh holds:
  - MEM_LATENCY (4)
  - MEM_WORD_WIDTH (16)
  - MEM_ADDR_WIDTH (16)
  - CACHE_BLOCK_WORDS (8)
- This include is shared with cache_fill_FSM.
- One sub-module, mem_pipe_stage: a DATA_WIDTH+1 bit register with sync active-low clear on the valid bit, built from the existing dff cell. It is instantiated LATENCY times via generate.
- The array stays in the top level.

Test Plan:
- Write 0xBEEF to 0x0010, then a read of 0x0010 at cycle 5 -> memory_data_valid=1 and memory_data=0xBEEF in cycle 9 only; memory_data=0 in cycles 6-8 and 10.
- Fill words 0x0100..0x010E with 0x1000..0x1007, then 8 back-to-back reads from cycle 20 -> valid high cycles 24..31, data 0x1000..0x1007 in order, busy low from cycle 32.
- Read 0x0011 after writing 0x0010=0x1234 -> returns 0x1234 (bit 0 ignored).
- Read 0x0200 (holding 0xAAAA) at cycle 0, write 0x0200=0x5555 at cycle 1 -> cycle-4 data is 0xAAAA; a read at cycle 2 returns 0x5555 at cycle 6.
- Issue 3 reads at cycles 0-2, assert rst_n=0 at cycle 3 -> no memory_data_valid pulse in cycles 3-10, busy=0 from cycle 4; array contents retained.
- Alternate enable=1/0 with reads over 10 cycles -> valid pulses spaced exactly 2 cycles apart, each LATENCY after its request.
